bp_io_reg_responder: RTL

BP_IO_REG_RESPONDER -- requirements
Module: bp_io_reg_responder

---
 rtl/bp_me_pkg.sv | 69 ++++++
 rtl/bp_io_reg_responder_bytesel.sv | 68 ++++++
 rtl/bp_io_reg_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// ---------------------------------------------------------------------------
// bp_me_pkg
//   Shared definitions for the memory-side I/O register responder:
//   - processor configuration selector and the widths derived from it
//   - BedRock mem message type / size enums and the mem header struct
//   - responder FSM state enum and register-window constants
// ---------------------------------------------------------------------------
package bp_me_pkg;

    // Processor configuration selector
    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int paddr_width_gp         = 40;
    localparam int bedrock_payload_width_gp = 16;

    // BedRock memory message types
    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'b0000,
        e_bedrock_mem_wr    = 4'b0001,
        e_bedrock_mem_uc_rd = 4'b0010,
        e_bedrock_mem_uc_wr = 4'b0011,
        e_bedrock_mem_pre   = 4'b0100,
        e_bedrock_mem_amo   = 4'b0101
    } bp_bedrock_mem_type_e;

    // BedRock message sizes, encoded as log2(bytes)
    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'b000,
        e_bedrock_msg_size_2   = 3'b001,
        e_bedrock_msg_size_4   = 3'b010,
        e_bedrock_msg_size_8   = 3'b011,
        e_bedrock_msg_size_16  = 3'b100,
        e_bedrock_msg_size_32  = 3'b101,
        e_bedrock_msg_size_64  = 3'b110,
        e_bedrock_msg_size_128 = 3'b111
    } bp_bedrock_msg_size_e;

    // BedRock mem header (shared by fwd and rev channels)
    typedef struct packed {
        logic [bedrock_payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e                size;
        logic [paddr_width_gp-1:0]           addr;
        logic [3:0]                          subop;
        bp_bedrock_mem_type_e                msg_type;
    } bp_bedrock_mem_header_s;

    // Responder FSM states
    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_io_reg_state_e;

    // Register window constants
    localparam int          bp_io_reg_width_gp     = 64;
    localparam int          bp_io_reg_bytes_gp     = 8;
    localparam int          bp_io_reg_off_width_gp = 3;
    localparam logic [39:0] bp_io_reg_base_addr_gp = 40'h00_0010_0000;

    // Fill (data beat) width for a given configuration
    function automatic int bp_fill_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 64;
            default:          return 64;
        endcase
    endfunction

endpackage

// File: rtl/bp_io_reg_responder_bytesel.sv
// ---------------------------------------------------------------------------
// bp_io_reg_responder_bytesel
//   Byte-lane steering for one 64-bit register access.
//   Ports:
//     size_i      - BedRock size code (sizes above 8 bytes act as 8 bytes)
//     addr_off_i  - addr[2:0]; aligned down to the access size internally
//     reg_i       - current register contents
//     wr_data_i   - write data, payload in the low bytes
//     wr_merged_o - register value after writing bytes [off, off+bytes)
//     rd_repl_o   - bytes [off, off+bytes) replicated across the fill width
// ---------------------------------------------------------------------------
module bp_io_reg_responder_bytesel
    import bp_me_pkg::*;
#(
    parameter int fill_width_p = 64
) (
    input  logic [2:0]              size_i,
    input  logic [2:0]              addr_off_i,
    input  logic [63:0]             reg_i,
    input  logic [63:0]             wr_data_i,
    output logic [63:0]             wr_merged_o,
    output logic [fill_width_p-1:0] rd_repl_o
);

    logic [2:0]  off_mask_s;
    logic [7:0]  base_en_s;
    logic [2:0]  off_s;
    logic [7:0]  byte_en_s;
    logic [63:0] shifted_wr_s;
    logic [63:0] extracted_s;
    logic [2:0]  jm_s;

    // Size decode: offset alignment mask and unshifted byte enables
    always_comb begin
        off_mask_s = 3'b000;
        base_en_s  = 8'hFF;
        case (size_i)
            3'd0: begin off_mask_s = 3'b111; base_en_s = 8'h01; end
            3'd1: begin off_mask_s = 3'b110; base_en_s = 8'h03; end
            3'd2: begin off_mask_s = 3'b100; base_en_s = 8'h0F; end
            default: begin off_mask_s = 3'b000; base_en_s = 8'hFF; end
        endcase
    end

    // Write merge and read extract/replicate
    always_comb begin
        off_s        = addr_off_i & off_mask_s;
        byte_en_s    = base_en_s << off_s;
        shifted_wr_s = wr_data_i << {off_s, 3'b000};
        extracted_s  = reg_i >> {off_s, 3'b000};
        wr_merged_o  = reg_i;
        rd_repl_o    = '0;
        jm_s         = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (byte_en_s[i]) begin
                wr_merged_o[i*8 +: 8] = shifted_wr_s[i*8 +: 8];
            end else begin
                wr_merged_o[i*8 +: 8] = reg_i[i*8 +: 8];
            end
        end
        // Output byte j takes accessed byte (j mod bytes); ~off_mask is bytes-1
        for (int j = 0; j < fill_width_p/8; j++) begin
            jm_s = 3'(j) & ~off_mask_s;
            rd_repl_o[j*8 +: 8] = extracted_s[{jm_s, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/bp_io_reg_responder.sv
// ---------------------------------------------------------------------------
// bp_io_reg_responder
//   Single-beat BedRock mem responder backed by els_p 64-bit registers at
//   base_addr_p. Accepts one fwd message, answers with one rev message that
//   echoes the fwd header. Writes return zero data; reads return the
//   addressed bytes replicated across the beat. Out-of-window accesses are
//   answered normally with no side effect and zero data.
//   Ports:
//     clk_i, reset_n_i                  - clock, async active-low reset
//     mem_fwd_header_i/data_i/v_i       - fwd message in
//     mem_fwd_ready_and_o               - fwd accept (ready&valid)
//     mem_rev_header_o/data_o/v_o       - rev message out (registered)
//     mem_rev_ready_and_i               - rev accept (ready&valid)
//   Build option: BP_IO_REG_RESPONDER_WRCNT_EN turns register els_p-1 into a
//   read-only counter of accepted in-window writes to the other registers.
// ---------------------------------------------------------------------------
module bp_io_reg_responder
    import bp_me_pkg::*;
#(
    parameter bp_params_e                bp_params_p = e_bp_default_cfg,
    parameter int                        els_p       = 8,
    parameter logic [paddr_width_gp-1:0] base_addr_p = 40'h00_0010_0000,
    localparam int bedrock_fill_width_p    = bp_fill_width(bp_params_p),
    localparam int mem_fwd_header_width_lp = $bits(bp_bedrock_mem_header_s),
    localparam int mem_rev_header_width_lp = $bits(bp_bedrock_mem_header_s)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i,
    input  logic [bedrock_fill_width_p-1:0]    mem_fwd_data_i,
    input  logic                               mem_fwd_v_i,
    output logic                               mem_fwd_ready_and_o,
    output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o,
    output logic [bedrock_fill_width_p-1:0]    mem_rev_data_o,
    output logic                               mem_rev_v_o,
    input  logic                               mem_rev_ready_and_i
);

    localparam int                  lg_els_lp   = $clog2(els_p);
    localparam int                  win_lsb_lp  = bp_io_reg_off_width_gp + lg_els_lp;
    localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

    bp_io_reg_state_e                state_q, state_d;
    bp_bedrock_mem_header_s          hdr_q, hdr_d;
    logic [bedrock_fill_width_p-1:0] data_q, data_d;
    logic                            ready_q, ready_d;
    logic                            v_q, v_d;
    logic [63:0]                     regs_q [els_p];
    logic [63:0]                     regs_d [els_p];

    bp_bedrock_mem_header_s          fwd_hdr_s;
    logic [lg_els_lp-1:0]            idx_s;
    logic                            in_range_s;
    logic                            is_wr_s;
    logic                            wr_allowed_s;
    logic                            accept_s;
    logic                            rev_done_s;
    logic [63:0]                     wr_merged_s;
    logic [bedrock_fill_width_p-1:0] rd_repl_s;

    assign fwd_hdr_s  = bp_bedrock_mem_header_s'(mem_fwd_header_i);
    assign idx_s      = fwd_hdr_s.addr[bp_io_reg_off_width_gp +: lg_els_lp];
    assign in_range_s = (fwd_hdr_s.addr[paddr_width_gp-1:win_lsb_lp]
                         == base_addr_p[paddr_width_gp-1:win_lsb_lp]);
    assign is_wr_s    = (fwd_hdr_s.msg_type == e_bedrock_mem_wr)
                      | (fwd_hdr_s.msg_type == e_bedrock_mem_uc_wr);
    // ready_q is only high in e_ready, so it doubles as the state qualifier
    assign accept_s   = mem_fwd_v_i & ready_q;
    assign rev_done_s = v_q & mem_rev_ready_and_i;

`ifdef BP_IO_REG_RESPONDER_WRCNT_EN
    assign wr_allowed_s = (idx_s != last_idx_lp);
`else
    assign wr_allowed_s = 1'b1;
`endif

    bp_io_reg_responder_bytesel #(
        .fill_width_p (bedrock_fill_width_p)
    ) u_bytesel (
        .size_i      (fwd_hdr_s.size),
        .addr_off_i  (fwd_hdr_s.addr[2:0]),
        .reg_i       (regs_q[idx_s]),
        .wr_data_i   (mem_fwd_data_i[63:0]),
        .wr_merged_o (wr_merged_s),
        .rd_repl_o   (rd_repl_s)
    );

    // Next-state, response capture and register update
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        regs_d  = regs_q;
        case (state_q)
            e_ready: begin
                if (accept_s) begin
                    state_d = e_resp;
                    hdr_d   = fwd_hdr_s;
                    if (is_wr_s) begin
                        data_d = '0;
                        if (in_range_s && wr_allowed_s) begin
                            regs_d[idx_s] = wr_merged_s;
`ifdef BP_IO_REG_RESPONDER_WRCNT_EN
                            regs_d[last_idx_lp] = regs_q[last_idx_lp] + 64'd1;
`endif
                        end else begin
                            regs_d = regs_q;
                        end
                    end else if (in_range_s) begin
                        data_d = rd_repl_s;
                    end else begin
                        data_d = '0;
                    end
                end else begin
                    state_d = e_ready;
                end
            end
            e_resp: begin
                if (rev_done_s) begin
                    state_d = e_ready;
                end else begin
                    state_d = e_resp;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
        ready_d = (state_d == e_ready);
        v_d     = (state_d == e_resp);
    end

    // State, response and register file flops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            v_q     <= 1'b0;
            for (int i = 0; i < els_p; i++) begin
                regs_q[i] <= 64'd0;
            end
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            v_q     <= v_d;
            regs_q  <= regs_d;
        end
    end

    assign mem_fwd_ready_and_o = ready_q;
    assign mem_rev_v_o         = v_q;
    assign mem_rev_header_o    = hdr_q;
    assign mem_rev_data_o      = data_q;

endmodule
